control_memoria_datos: RTL and testbench

Access controller in front of the byte-write data memory (1024 x 32, 1-cycle read latency, per-byte write enables). It turns MIPS MEM-stage loads and stores (byte, halfword, word; signed or unsigned) into word address, byte-lane write mask and replicated write data, and sign/zero-extends read data. It also arbitrates the memory with the debug unit, running a sequential dump of DUMP_WORDS words with a valid/ack handshake. It stalls the pipeline while a dump owns the memory.

---
 rtl/control_memoria_datos_pkg.sv | 29 ++
 rtl/control_memoria_datos_extensor_carga.sv | 34 +++
 rtl/control_memoria_datos.sv | 176 +++++++++++++++++
 tb/tb_control_memoria_datos.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_memoria_datos_pkg.sv
// Shared encodings for the data-memory access controller.
// Size codes, dump FSM states and the lane-mask helper.
package control_memoria_datos_pkg;

  localparam int NB_LANES = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_D_READ = 3'd1;
  localparam logic [2:0] ST_D_WAIT = 3'd2;
  localparam logic [2:0] ST_D_HOLD = 3'd3;
  localparam logic [2:0] ST_D_DONE = 3'd4;

  // Little-endian byte-lane enables for a store of the given size.
  function automatic logic [NB_LANES-1:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    unique case (1'b1)
      size == SIZE_BYTE: lane_mask = 4'b0001 << off;
      size == SIZE_HALF: lane_mask = 4'b0011 << off;
      default:           lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/control_memoria_datos_extensor_carga.sv
// Load lane select and sign/zero extension.
// Purely combinational so the writeback stage can reuse it.
module extensor_carga
  import control_memoria_datos_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] data_i,
  input  logic [1:0]         offset_i,
  input  logic [1:0]         size_i,
  input  logic               unsigned_i,
  output logic [NB_DATA-1:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;
  logic        sgn_b;
  logic        sgn_h;

  assign byte_w = data_i[{offset_i, 3'b000} +: 8];
  assign half_w = offset_i[1] ? data_i[31:16] : data_i[15:0];
  assign sgn_b  = ~unsigned_i & byte_w[7];
  assign sgn_h  = ~unsigned_i & half_w[15];

  always_comb begin
    data_o = data_i;
    unique case (1'b1)
      size_i == SIZE_BYTE: data_o = {{24{sgn_b}}, byte_w};
      size_i == SIZE_HALF: data_o = {{16{sgn_h}}, half_w};
      default:             data_o = data_i;
    endcase
  end

endmodule

// File: rtl/control_memoria_datos.sv
// MEM-stage access controller for the byte-write data memory.
// Also arbitrates the memory with the debug unit's word dump.
module control_memoria_datos
  import control_memoria_datos_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 10,
  parameter int NB_ADDR_BYTE = 12,
  parameter int DUMP_WORDS   = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_soft_reset,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic [NB_ADDR_BYTE-1:0] i_addr,
  input  logic [NB_DATA-1:0]      i_data_write,
  input  logic [1:0]              i_size,
  input  logic                    i_unsigned,
  output logic [NB_DATA-1:0]      o_data_read,
  output logic                    o_misaligned,
  output logic                    o_busy,
  input  logic                    i_dump_start,
  input  logic                    i_dump_ack,
  output logic                    o_dump_valid,
  output logic [NB_DATA-1:0]      o_dump_data,
  output logic [NB_ADDR-1:0]      o_dump_addr,
  output logic                    o_dump_done,
  output logic [NB_ADDR-1:0]      o_mem_addr,
  output logic [NB_DATA-1:0]      o_mem_data,
  output logic [NB_LANES-1:0]     o_mem_wea,
  output logic                    o_mem_ena,
  input  logic [NB_DATA-1:0]      i_mem_data
);

  localparam logic [NB_ADDR-1:0] CNT_LAST = NB_ADDR'(DUMP_WORDS - 1);
  localparam logic [NB_ADDR-1:0] CNT_ONE  = NB_ADDR'(1);

  logic [2:0]         state_q, state_d;
  logic [NB_ADDR-1:0] cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [1:0]         off_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               ld_q;
  logic [NB_DATA-1:0] hold_q;
  logic [NB_DATA-1:0] dump_q;
  logic [NB_DATA-1:0] ext_data;
  logic [NB_DATA-1:0] wdata;

  logic [1:0] off;
  logic       access;
  logic       is_byte;
  logic       is_half;
  logic       is_word;
  logic       idle_like;
  logic       serve;
  logic       ld_go;

  assign off     = i_addr[1:0];
  assign access  = i_mem_read | i_mem_write;
  assign is_byte = i_size == SIZE_BYTE;
  assign is_half = i_size == SIZE_HALF;
  assign is_word = (i_size == SIZE_WORD) | (i_size == 2'b11);

  assign o_misaligned = access
    & ((is_half & off[0]) | (is_word & (off != 2'b00)));

  // D_DONE releases the pipeline, so it may be served there too.
  assign idle_like = ((state_q == ST_IDLE) & ~pend_q)
                   | (state_q == ST_D_DONE);
  assign serve     = idle_like & access & ~o_misaligned;
  assign ld_go     = serve & i_mem_read & ~i_mem_write;

  assign o_busy       = ~idle_like;
  assign o_dump_valid = state_q == ST_D_HOLD;
  assign o_dump_done  = state_q == ST_D_DONE;
  assign o_dump_data  = dump_q;
  assign o_dump_addr  = cnt_q;

  always_comb begin
    wdata = i_data_write;
    unique case (1'b1)
      is_byte: wdata = {4{i_data_write[7:0]}};
      is_half: wdata = {2{i_data_write[15:0]}};
      default: wdata = i_data_write;
    endcase
  end

  always_comb begin
    o_mem_addr = i_addr[NB_ADDR_BYTE-1:2];
    o_mem_data = wdata;
    o_mem_wea  = '0;
    o_mem_ena  = 1'b0;
    if (!i_soft_reset) begin
      o_mem_ena = 1'b0;
    end else if (state_q == ST_D_READ) begin
      o_mem_addr = cnt_q;
      o_mem_ena  = 1'b1;
    end else if (serve) begin
      o_mem_ena = 1'b1;
      if (i_mem_write) o_mem_wea = lane_mask(i_size, off);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_dump_start | pend_q) begin
          state_d = ST_D_READ;
          cnt_d   = '0;
          pend_d  = serve;
        end
      end
      ST_D_READ: begin
        pend_d  = 1'b0;
        state_d = ST_D_WAIT;
      end
      ST_D_WAIT: state_d = ST_D_HOLD;
      ST_D_HOLD: begin
        if (i_dump_ack) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_D_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = ST_D_READ;
          end
        end
      end
      ST_D_DONE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_soft_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      ld_q    <= 1'b0;
      hold_q  <= '0;
      dump_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ld_q    <= ld_go;
      if (ld_go) begin
        off_q  <= off;
        size_q <= i_size;
        uns_q  <= i_unsigned;
      end
      if (ld_q) hold_q <= ext_data;
      if (state_q == ST_D_WAIT) dump_q <= i_mem_data;
    end
  end

  extensor_carga #(
    .NB_DATA(NB_DATA)
  ) u_ext (
    .data_i    (i_mem_data),
    .offset_i  (off_q),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_o    (ext_data)
  );

  // Fresh lane data right after a load, otherwise the last result.
  assign o_data_read = ld_q ? ext_data : hold_q;

endmodule

// File: tb/tb_control_memoria_datos.sv
// Bench for control_memoria_datos: vector table, random ops
// against a byte-array model, and dump handshake sequences.
module tb_control_memoria_datos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, uns, start, ack;
  logic [11:0] addr;
  logic [31:0] wd;
  logic [1:0]  size;
  logic [31:0] data_read;
  logic        mis, busy;
  logic        dvalid, ddone;
  logic [31:0] ddata;
  logic [9:0]  daddr;
  logic [9:0]  maddr;
  logic [31:0] mdata;
  logic [3:0]  mwea;
  logic        mena;
  logic [31:0] ram_q;

  logic [31:0] ram [0:1023];
  logic [7:0]  refm [0:4095];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  control_memoria_datos #(
    .NB_DATA(32), .NB_ADDR(10),
    .NB_ADDR_BYTE(12), .DUMP_WORDS(4)
  ) dut (
    .i_clk(clk), .i_soft_reset(rst_n),
    .i_mem_read(rd), .i_mem_write(wr),
    .i_addr(addr), .i_data_write(wd),
    .i_size(size), .i_unsigned(uns),
    .o_data_read(data_read), .o_misaligned(mis),
    .o_busy(busy), .i_dump_start(start),
    .i_dump_ack(ack), .o_dump_valid(dvalid),
    .o_dump_data(ddata), .o_dump_addr(daddr),
    .o_dump_done(ddone), .o_mem_addr(maddr),
    .o_mem_data(mdata), .o_mem_wea(mwea),
    .o_mem_ena(mena), .i_mem_data(ram_q)
  );

  always @(posedge clk) begin
    if (mena) begin
      ram_q <= ram[maddr];
      for (int k = 0; k < 4; k++)
        if (mwea[k]) ram[maddr][8*k +: 8] <= mdata[8*k +: 8];
    end
  end

  always @(negedge clk) if (ddone) done_cnt++;

  typedef struct {
    logic        rd, wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    logic        uns;
    logic        ena;
    logic [3:0]  wea;
    logic [9:0]  maddr;
    logic [31:0] mdata;
    logic        mis;
    logic [31:0] rdata;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0; start = 1'b0; ack = 1'b0;
  endtask

  task automatic drive(input logic r, input logic w,
                       input logic [11:0] a,
                       input logic [31:0] d,
                       input logic [1:0] s, input logic u);
    rd = r; wr = w; addr = a; wd = d; size = s; uns = u;
  endtask

  task automatic store_word(input logic [11:0] a,
                            input logic [31:0] d);
    drive(1'b0, 1'b1, a, d, 2'd2, 1'b0);
    cyc();
    idle();
  endtask

  task automatic wait_valid(input int w, input logic [31:0] d);
    int n = 0;
    while (!dvalid && n < 10) begin
      cyc();
      n++;
    end
    if (!dvalid) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout word=%0d act=0 exp=1", w);
    end else begin
      chk($sformatf("dump_addr%0d", w), 32'(daddr), 32'(w));
      chk($sformatf("dump_data%0d", w), ddata, d);
    end
  endtask

  initial begin
    logic [31:0] exp_rd;
    logic [31:0] snap;
    logic [63:0] v;
    int n;
    logic acc, emis;

    idle();
    drive(1'b1, 1'b1, 12'h010, 32'h0, 2'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_ena", 32'(mena), 32'd0);
    chk("rst_wea", 32'(mwea), 32'd0);
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(dvalid), 32'd0);
    chk("rst_done", 32'(ddone), 32'd0);
    chk("rst_rdata", data_read, 32'd0);
    idle();
    rst_n = 1'b1;
    cyc();

    tv[0]  = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 2'd2, 1'b0,
               1'b1, 4'hF, 10'h4, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b0, 12'h010, 32'h0, 2'd2, 1'b0,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'hDEADBEEF};
    tv[2]  = '{1'b0, 1'b1, 12'h013, 32'h1A5, 2'd0, 1'b0,
               1'b1, 4'h8, 10'h4, 32'hA5A5A5A5, 1'b0, 32'hDEADBEEF};
    tv[3]  = '{1'b1, 1'b0, 12'h013, 32'h0, 2'd0, 1'b0,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'hFFFFFFA5};
    tv[4]  = '{1'b1, 1'b0, 12'h013, 32'h0, 2'd0, 1'b1,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'h000000A5};
    tv[5]  = '{1'b0, 1'b1, 12'h012, 32'h8001, 2'd1, 1'b0,
               1'b1, 4'hC, 10'h4, 32'h80018001, 1'b0, 32'h000000A5};
    tv[6]  = '{1'b1, 1'b0, 12'h012, 32'h0, 2'd1, 1'b0,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'hFFFF8001};
    tv[7]  = '{1'b1, 1'b0, 12'h012, 32'h0, 2'd1, 1'b1,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'h00008001};
    tv[8]  = '{1'b1, 1'b0, 12'h011, 32'h0, 2'd1, 1'b0,
               1'b0, 4'h0, 10'h4, 32'h0, 1'b1, 32'h00008001};
    tv[9]  = '{1'b0, 1'b1, 12'h012, 32'h12345678, 2'd2, 1'b0,
               1'b0, 4'h0, 10'h4, 32'h0, 1'b1, 32'h00008001};
    tv[10] = '{1'b1, 1'b0, 12'h010, 32'h0, 2'd2, 1'b0,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'h8001BEEF};
    tv[11] = '{1'b1, 1'b1, 12'h010, 32'h77, 2'd0, 1'b0,
               1'b1, 4'h1, 10'h4, 32'h77777777, 1'b0, 32'h8001BEEF};
    tv[12] = '{1'b1, 1'b0, 12'h010, 32'h0, 2'd2, 1'b0,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'h8001BE77};
    tv[13] = '{1'b1, 1'b0, 12'h011, 32'h0, 2'd0, 1'b0,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'hFFFFFFBE};
    tv[14] = '{1'b1, 1'b0, 12'h012, 32'h0, 2'd0, 1'b1,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'h00000001};
    tv[15] = '{1'b1, 1'b0, 12'h010, 32'h0, 2'd3, 1'b0,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'h8001BE77};
    tv[16] = '{1'b1, 1'b0, 12'h010, 32'h0, 2'd1, 1'b0,
               1'b1, 4'h0, 10'h4, 32'h0, 1'b0, 32'hFFFFBE77};

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].rd, tv[i].wr, tv[i].addr,
            tv[i].wd, tv[i].size, tv[i].uns);
      #1;
      chk($sformatf("v%0d_mis", i), 32'(mis), 32'(tv[i].mis));
      chk($sformatf("v%0d_ena", i), 32'(mena), 32'(tv[i].ena));
      chk($sformatf("v%0d_wea", i), 32'(mwea), 32'(tv[i].wea));
      if (tv[i].ena)
        chk($sformatf("v%0d_maddr", i), 32'(maddr),
            32'(tv[i].maddr));
      if (tv[i].ena && tv[i].wr)
        chk($sformatf("v%0d_mdata", i), mdata, tv[i].mdata);
      cyc();
      idle();
      chk($sformatf("v%0d_rdata", i), data_read, tv[i].rdata);
    end

    // Random loads/stores over a zeroed 64-byte window.
    for (int w = 0; w < 16; w++) begin
      store_word(12'h100 + 12'(4 * w), 32'h0);
      for (int k = 0; k < 4; k++) refm[256 + 4 * w + k] = 8'h0;
    end
    exp_rd = data_read;
    for (int it = 0; it < 400; it++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            12'h100 + 12'($urandom_range(0, 63)), $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      acc = rd | wr;
      emis = acc && (int'(addr) % n != 0);
      #1;
      chk($sformatf("r%0d_mis", it), 32'(mis), 32'(emis));
      chk($sformatf("r%0d_ena", it), 32'(mena), 32'(acc && !emis));
      cyc();
      if (wr && !emis) begin
        for (int k = 0; k < n; k++)
          refm[int'(addr) + k] = wd[8*k +: 8];
      end else if (rd && !emis) begin
        v = 64'h0;
        for (int k = 0; k < n; k++)
          v = v | (64'(refm[int'(addr) + k]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1])
          v = v - (64'h1 << (8 * n));
        exp_rd = v[31:0];
      end
      idle();
      chk($sformatf("r%0d_rdata", it), data_read, exp_rd);
    end

    // Dump of 4 words with a 3-cycle ack delay.
    store_word(12'h000, 32'h11);
    store_word(12'h004, 32'h22);
    store_word(12'h008, 32'h33);
    store_word(12'h00C, 32'h44);
    start = 1'b1;
    #1;
    chk("d_busy_pre", 32'(busy), 32'd0);
    cyc();
    start = 1'b0;
    ack = 1'b1;
    chk("d_busy_rd", 32'(busy), 32'd1);
    chk("d_ena_rd", 32'(mena), 32'd1);
    chk("d_addr_rd", 32'(maddr), 32'd0);
    cyc();
    ack = 1'b0;
    for (int w = 0; w < 4; w++) begin
      wait_valid(w, 32'h11 * 32'(w + 1));
      snap = ddata;
      for (int h = 0; h < 3; h++) begin
        cyc();
        chk($sformatf("d%0d_hold_v", w), 32'(dvalid), 32'd1);
        chk($sformatf("d%0d_hold_d", w), ddata, snap);
        chk($sformatf("d%0d_busy", w), 32'(busy), 32'd1);
      end
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      chk($sformatf("d%0d_ackv", w), 32'(dvalid), 32'd0);
    end
    chk("d_done", 32'(ddone), 32'd1);
    chk("d_busy_done", 32'(busy), 32'd0);
    cyc();
    chk("d_done_pulse", 32'(ddone), 32'd0);
    chk("d_done_cnt", 32'(done_cnt), 32'd1);

    // Start together with a store, then reset inside word 2.
    drive(1'b0, 1'b1, 12'h020, 32'hCAFE0001, 2'd2, 1'b0);
    start = 1'b1;
    #1;
    chk("s_ena", 32'(mena), 32'd1);
    chk("s_wea", 32'(mwea), 32'hF);
    cyc();
    idle();
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_dump_addr", 32'(maddr), 32'd0);
    for (int w = 0; w < 2; w++) begin
      wait_valid(w, 32'h11 * 32'(w + 1));
      ack = 1'b1;
      cyc();
      ack = 1'b0;
    end
    wait_valid(2, 32'h33);
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("x_valid", 32'(dvalid), 32'd0);
    chk("x_busy", 32'(busy), 32'd0);
    chk("x_ena", 32'(mena), 32'd0);
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("x_done_cnt", 32'(done_cnt), 32'd1);
    chk("x_busy_after", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 12'h020, 32'h0, 2'd2, 1'b0);
    cyc();
    idle();
    chk("x_store_kept", data_read, 32'hCAFE0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
